// File: rtl/button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// button_conditioner_pkg
//   Shared definitions for the push-button front end:
//   - channel indices of the four board buttons (Up, Down, TC, Lp)
//   - state encoding of the per-channel auto-repeat FSM
//   - helper that builds the default auto-repeat mask (Up and Down repeat)
// -----------------------------------------------------------------------------
package button_conditioner_pkg;

  localparam int BTN_UP        = 0;
  localparam int BTN_DOWN      = 1;
  localparam int BTN_TC        = 2;
  localparam int BTN_LP        = 3;
  localparam int N_BTN_DEFAULT = 4;

  // Auto-repeat FSM state. IDLE covers both "not pressed" and
  // "repeat disabled for this channel".
  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_WAIT   = 2'd1,
    REP_REPEAT = 2'd2
  } rep_state_e;

  // Only the tone-stepping keys repeat; mode keys (TC, Lp) fire once per press.
  function automatic logic [N_BTN_DEFAULT-1:0] default_rep_mask();
    logic [N_BTN_DEFAULT-1:0] m;
    m           = '0;
    m[BTN_UP]   = 1'b1;
    m[BTN_DOWN] = 1'b1;
    m[BTN_TC]   = 1'b0;
    m[BTN_LP]   = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One button channel: 2-FF synchroniser, counter-based debounce, registered
//   press/release edge pulses and an optional auto-repeat FSM.
//
//   Ports:
//     clk_i      system clock, rising edge
//     rst_n_i    asynchronous active-low reset
//     btn_raw_i  raw pad level, 1 = pressed (only the synchroniser reads it)
//     level_o    debounced level
//     pulse_o    1-cycle pulse on accepted press and on each auto-repeat
//     rel_o      1-cycle pulse on accepted release
//     state_o    auto-repeat FSM state (debug visibility)
//
//   Handshake: none; all outputs are plain registered levels/pulses, valid
//   every cycle, with no backpressure.
// -----------------------------------------------------------------------------
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 20,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000,
  parameter int REP_W      = 25,
  parameter bit REP_EN     = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       btn_raw_i,
  output logic       level_o,
  output logic       pulse_o,
  output logic       rel_o,
  output rep_state_e state_o
);

  localparam logic [DEB_W-1:0] DEB_TC    = DEB_W'(DEB_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_TC  = REP_W'(REP_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_TC = REP_W'(REP_PERIOD - 1);

  logic [1:0]       sync_q;
  logic             s;
  logic [DEB_W-1:0] dc_q, dc_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             rel_q, rel_d;
  logic             differs, deb_done, accept_press, accept_release;
  rep_state_e       state_q;
  logic [REP_W-1:0] rc_q;
  logic             rep_fire;

  assign s = sync_q[1];

  always_comb begin
    differs        = s ^ level_q;
    // Terminal-count compare comes first so dc never wraps.
    deb_done       = differs && (dc_q == DEB_TC);
    accept_press   = deb_done && s;
    accept_release = deb_done && !s;

    dc_d = '0;
    if (differs && !deb_done) begin
      dc_d = dc_q + 1'b1;
    end
    level_d = deb_done ? s : level_q;

    // A release accepted in the same cycle as a terminal count suppresses
    // the repeat pulse.
    rep_fire = 1'b0;
    if (!accept_release) begin
      if ((state_q == REP_WAIT) && (rc_q == DELAY_TC)) begin
        rep_fire = 1'b1;
      end
      if ((state_q == REP_REPEAT) && (rc_q == PERIOD_TC)) begin
        rep_fire = 1'b1;
      end
    end

    pulse_d = accept_press | rep_fire;
    rel_d   = accept_release;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q  <= '0;
      dc_q    <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw_i};
      dc_q    <= dc_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      rel_q   <= rel_d;
    end
  end

  generate
    if (REP_EN) begin : g_rep
      // Auto-repeat: WAIT counts the initial hold delay, REPEAT the period.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          state_q <= REP_IDLE;
          rc_q    <= '0;
        end else begin
          case (state_q)
            REP_IDLE: begin
              rc_q <= '0;
              if (accept_press) begin
                state_q <= REP_WAIT;
              end
            end
            REP_WAIT: begin
              if (accept_release || !level_q) begin
                state_q <= REP_IDLE;
                rc_q    <= '0;
              end else if (rc_q == DELAY_TC) begin
                state_q <= REP_REPEAT;
                rc_q    <= '0;
              end else begin
                rc_q <= rc_q + 1'b1;
              end
            end
            REP_REPEAT: begin
              if (accept_release || !level_q) begin
                state_q <= REP_IDLE;
                rc_q    <= '0;
              end else if (rc_q == PERIOD_TC) begin
                rc_q <= '0;
              end else begin
                rc_q <= rc_q + 1'b1;
              end
            end
            default: begin
              state_q <= REP_IDLE;
              rc_q    <= '0;
            end
          endcase
        end
      end
    end else begin : g_norep
      // Non-repeating channel: FSM parked in IDLE, counter held at zero.
      assign state_q = REP_IDLE;
      assign rc_q    = '0;
    end
  endgenerate

  assign level_o = level_q;
  assign pulse_o = pulse_q;
  assign rel_o   = rel_q;
  assign state_o = state_q;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Push-button front end for the chroma control stage. Every raw pad input is
//   synchronised, debounced and edge-detected; Up and Down also auto-repeat
//   while held so a held key steps the tone continuously.
//
//   Ports:
//     Clk            system clock, rising edge
//     reset          asynchronous active-low reset
//     btn_raw        raw pad levels, 1 = pressed; [0]Up [1]Down [2]TC [3]Lp
//     btn_level      debounced level per channel
//     btn_pulse      1-cycle pulse on accepted press and on each auto-repeat
//     btn_rel        1-cycle pulse on accepted release
//     dbg_rep_state  per-channel auto-repeat FSM state, 2 bits per channel
//
//   Channels are fully independent; no cross-channel logic exists here.
// -----------------------------------------------------------------------------
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int               N_BTN      = N_BTN_DEFAULT,
  parameter int               DEB_CYCLES = 500000,
  parameter int               DEB_W      = 20,
  parameter int               REP_DELAY  = 25000000,
  parameter int               REP_PERIOD = 5000000,
  parameter int               REP_W      = 25,
  parameter logic [N_BTN-1:0] REP_MASK   = N_BTN'(default_rep_mask())
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic [N_BTN-1:0]   btn_raw,
  output logic [N_BTN-1:0]   btn_level,
  output logic [N_BTN-1:0]   btn_pulse,
  output logic [N_BTN-1:0]   btn_rel,
  output logic [2*N_BTN-1:0] dbg_rep_state
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    rep_state_e st;

    debounce_channel #(
      .DEB_CYCLES (DEB_CYCLES),
      .DEB_W      (DEB_W),
      .REP_DELAY  (REP_DELAY),
      .REP_PERIOD (REP_PERIOD),
      .REP_W      (REP_W),
      .REP_EN     (REP_MASK[i])
    ) u_ch (
      .clk_i     (Clk),
      .rst_n_i   (reset),
      .btn_raw_i (btn_raw[i]),
      .level_o   (btn_level[i]),
      .pulse_o   (btn_pulse[i]),
      .rel_o     (btn_rel[i]),
      .state_o   (st)
    );

    assign dbg_rep_state[2*i +: 2] = st;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//   Directed bench for button_conditioner with short debounce/repeat timings
//   (DEB_CYCLES=4, REP_DELAY=10, REP_PERIOD=3). "Cycle k" means the value
//   sampled 1 ns after the k-th rising edge following an input change.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int N_BTN      = 4;
  localparam int DEB_CYCLES = 4;
  localparam int DEB_W      = 3;
  localparam int REP_DELAY  = 10;
  localparam int REP_PERIOD = 3;
  localparam int REP_W      = 4;

  logic         clk;
  logic         rst_n;
  logic [3:0]   btn_raw;
  logic [3:0]   btn_level;
  logic [3:0]   btn_pulse;
  logic [3:0]   btn_rel;
  logic [7:0]   dbg_state;

  int errors = 0;
  int checks = 0;

  button_conditioner #(
    .N_BTN      (N_BTN),
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W),
    .REP_DELAY  (REP_DELAY),
    .REP_PERIOD (REP_PERIOD),
    .REP_W      (REP_W),
    .REP_MASK   (4'b0011)
  ) dut (
    .Clk           (clk),
    .reset         (rst_n),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .btn_pulse     (btn_pulse),
    .btn_rel       (btn_rel),
    .dbg_rep_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n   = 1'b0;
    btn_raw = 4'b0000;
    #3;
    checks++;
    if ({btn_level, btn_pulse, btn_rel} !== 12'h000) begin
      errors++;
      $display("FAIL reset_async: got %b expected 000000000000", {btn_level, btn_pulse, btn_rel});
    end
    tick(3);
    checks++;
    if ({btn_level, btn_pulse, btn_rel, dbg_state} !== 20'h0) begin
      errors++;
      $display("FAIL reset_held: got %b expected all zero", {btn_level, btn_pulse, btn_rel, dbg_state});
    end
    rst_n = 1'b1;
    tick(1);
    checks++;
    if ({btn_level, btn_pulse, btn_rel} !== 12'h000) begin
      errors++;
      $display("FAIL reset_release: got %b expected all zero", {btn_level, btn_pulse, btn_rel});
    end
  endtask

  task automatic test_idle();
    btn_raw = 4'b0000;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      checks++;
      if ({btn_level, btn_pulse, btn_rel} !== 12'h000) begin
        errors++;
        $display("FAIL idle cycle %0d: got %b expected all zero", k, {btn_level, btn_pulse, btn_rel});
      end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_level, exp_pulse, exp_rel;
    btn_raw = 4'b0100;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      exp_level = (k >= 6) ? 4'b0100 : 4'b0000;
      exp_pulse = (k == 6) ? 4'b0100 : 4'b0000;
      checks++;
      if (btn_level !== exp_level) begin
        errors++;
        $display("FAIL tc_level cycle %0d: got %b expected %b", k, btn_level, exp_level);
      end
      checks++;
      if (btn_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL tc_pulse cycle %0d: got %b expected %b", k, btn_pulse, exp_pulse);
      end
      checks++;
      if (dbg_state !== 8'h00) begin
        errors++;
        $display("FAIL tc_no_repeat_state cycle %0d: got %h expected 00", k, dbg_state);
      end
    end
    btn_raw = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      exp_level = (k < 6) ? 4'b0100 : 4'b0000;
      exp_rel   = (k == 6) ? 4'b0100 : 4'b0000;
      checks++;
      if (btn_level !== exp_level) begin
        errors++;
        $display("FAIL tc_rel_level cycle %0d: got %b expected %b", k, btn_level, exp_level);
      end
      checks++;
      if (btn_rel !== exp_rel) begin
        errors++;
        $display("FAIL tc_rel_pulse cycle %0d: got %b expected %b", k, btn_rel, exp_rel);
      end
      checks++;
      if (btn_pulse !== 4'b0000) begin
        errors++;
        $display("FAIL tc_rel_nopulse cycle %0d: got %b expected 0000", k, btn_pulse);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      btn_raw = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      tick(1);
      checks++;
      if ({btn_level, btn_pulse} !== 8'h00) begin
        errors++;
        $display("FAIL bounce_glitch step %0d: got %b expected 00000000", i, {btn_level, btn_pulse});
      end
    end
    btn_raw = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      exp_v = (k == 6) ? 4'b0001 : 4'b0000;
      checks++;
      if (btn_level !== exp_v) begin
        errors++;
        $display("FAIL bounce_level cycle %0d: got %b expected %b", k, btn_level, exp_v);
      end
      checks++;
      if (btn_pulse !== exp_v) begin
        errors++;
        $display("FAIL bounce_pulse cycle %0d: got %b expected %b", k, btn_pulse, exp_v);
      end
    end
  endtask

  // Continues from test_bounce: Up was accepted at j=0 and is still held.
  task automatic test_repeat();
    logic [3:0] exp_level, exp_pulse, exp_rel;
    logic [1:0] exp_st;
    for (int j = 1; j <= 55; j++) begin
      if (j == 41) btn_raw = 4'b0000;
      tick(1);
      exp_level = (j < 46) ? 4'b0001 : 4'b0000;
      exp_pulse = (j >= 10 && j < 46 && ((j - 10) % 3) == 0) ? 4'b0001 : 4'b0000;
      exp_rel   = (j == 46) ? 4'b0001 : 4'b0000;
      exp_st    = (j < 10) ? 2'd1 : ((j < 46) ? 2'd2 : 2'd0);
      checks++;
      if (btn_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL repeat_pulse +%0d: got %b expected %b", j, btn_pulse, exp_pulse);
      end
      checks++;
      if (btn_level !== exp_level) begin
        errors++;
        $display("FAIL repeat_level +%0d: got %b expected %b", j, btn_level, exp_level);
      end
      checks++;
      if (btn_rel !== exp_rel) begin
        errors++;
        $display("FAIL repeat_rel +%0d: got %b expected %b", j, btn_rel, exp_rel);
      end
      checks++;
      if (dbg_state[1:0] !== exp_st) begin
        errors++;
        $display("FAIL repeat_state +%0d: got %0d expected %0d", j, dbg_state[1:0], exp_st);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_level, exp_pulse, exp_rel;
    btn_raw = 4'b1001;
    for (int j = 1; j <= 30; j++) begin
      if (j == 21) btn_raw = 4'b0000;
      tick(1);
      exp_level = (j >= 6 && j < 26) ? 4'b1001 : 4'b0000;
      exp_rel   = (j == 26) ? 4'b1001 : 4'b0000;
      if (j == 6) exp_pulse = 4'b1001;
      else if (j >= 16 && j < 26 && ((j - 16) % 3) == 0) exp_pulse = 4'b0001;
      else exp_pulse = 4'b0000;
      checks++;
      if (btn_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL simul_pulse cycle %0d: got %b expected %b", j, btn_pulse, exp_pulse);
      end
      checks++;
      if (btn_level !== exp_level) begin
        errors++;
        $display("FAIL simul_level cycle %0d: got %b expected %b", j, btn_level, exp_level);
      end
      checks++;
      if (btn_rel !== exp_rel) begin
        errors++;
        $display("FAIL simul_rel cycle %0d: got %b expected %b", j, btn_rel, exp_rel);
      end
      checks++;
      if (dbg_state[7:6] !== 2'd0) begin
        errors++;
        $display("FAIL simul_lp_state cycle %0d: got %0d expected 0", j, dbg_state[7:6]);
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    logic [3:0] exp_v;
    btn_raw = 4'b0001;
    tick(6);
    checks++;
    if ({btn_level, btn_pulse} !== 8'b0001_0001) begin
      errors++;
      $display("FAIL rmr_press: got %b expected 00010001", {btn_level, btn_pulse});
    end
    tick(12);
    checks++;
    if (dbg_state[1:0] !== 2'd2) begin
      errors++;
      $display("FAIL rmr_in_repeat: got %0d expected 2", dbg_state[1:0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({btn_level, btn_pulse, btn_rel, dbg_state} !== 20'h0) begin
      errors++;
      $display("FAIL rmr_async_clear: got %b expected all zero", {btn_level, btn_pulse, btn_rel, dbg_state});
    end
    tick(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      exp_v = (k >= 6) ? 4'b0001 : 4'b0000;
      checks++;
      if (btn_level !== exp_v) begin
        errors++;
        $display("FAIL rmr_fresh_level cycle %0d: got %b expected %b", k, btn_level, exp_v);
      end
      exp_v = (k == 6) ? 4'b0001 : 4'b0000;
      checks++;
      if (btn_pulse !== exp_v) begin
        errors++;
        $display("FAIL rmr_fresh_pulse cycle %0d: got %b expected %b", k, btn_pulse, exp_v);
      end
    end
    btn_raw = 4'b0000;
    tick(10);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    btn_raw = 4'b0000;
    rst_n   = 1'b0;
    test_reset();
    test_idle();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_simultaneous();
    test_reset_mid_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
